// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks register indices FIRST_REG..LAST_REG, reading each
// value from a combinational register file port and streaming it out over a
// valid/ready interface, one word every two cycles when not backpressured.
module reg_dump_unit #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] idx;
    logic       accept;
    logic       at_last;
    logic       launch;

    assign accept  = out_valid && out_ready;
    assign at_last = (idx == LAST_IDX);
    assign launch  = start && !abort;

    // State register; reset forces IDLE regardless of any handshake in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort wins over start and over a final handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept) begin
                    state_next = at_last ? IDLE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Index counter, captured output word and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx       <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_index <= 5'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        idx <= FIRST_IDX;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else begin
                        // Snapshot the register now so later writes cannot alter this word.
                        out_data  <= rf_rdata;
                        out_index <= idx;
                        out_last  <= at_last;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        if (at_last) begin
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Status and register file address; the address parks at 0 while idle.
    always_comb begin
        busy    = (state != IDLE);
        rf_addr = (state == IDLE) ? 5'd0 : idx;
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: randomized scoreboard bench for reg_dump_unit. The model
// predicts the dumped word stream from a snapshot of the register file taken
// when a dump is requested; a monitor pops predictions on every handshake.
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        start1;
    logic [4:0]  rf_addr1;
    logic [31:0] rf_rdata1;
    logic        out_valid1;
    logic [31:0] out_data1;
    logic [4:0]  out_index1;
    logic        out_last1;
    logic        busy1;
    logic        done1;

    logic [31:0] rf [32];
    assign rf_rdata  = rf[rf_addr];
    assign rf_rdata1 = rf[rf_addr1];

    reg_dump_unit dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    reg_dump_unit #(.FIRST_REG(5), .LAST_REG(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .rf_addr(rf_addr1), .rf_rdata(rf_rdata1),
        .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1),
        .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
    } word_t;

    word_t      sb_q[$];
    word_t      exp_w;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_seen = 0;
    int         done_cyc = 0;
    int         last_hs = -1;
    bit         spacing_en = 1'b0;
    int         ready_mode = 0;
    logic [4:0] hold_idx = 5'd0;
    int         start_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready generator: always ready, random, stalled, or stalled on hold_idx only.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = !(out_valid && out_index == hold_idx);
        endcase
    end

    // Monitor: compare each accepted word with the oldest prediction, count done pulses.
    always @(negedge clk) begin
        if (!spacing_en) last_hs = -1;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got index %0d data 0x%0h, expected no word", out_index, out_data);
            end else begin
                exp_w = sb_q.pop_front();
                chk("word_index", 64'(out_index), 64'(exp_w.index));
                chk("word_data",  64'(out_data),  64'(exp_w.data));
                chk("word_last",  64'(out_last),  64'(exp_w.last));
            end
            if (spacing_en) begin
                if (last_hs >= 0) chk("word_spacing", 64'(cyc - last_hs), 64'd2);
                last_hs = cyc;
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    task automatic issue_dump();
        for (int i = 0; i < 32; i++) begin
            sb_q.push_back(word_t'{rf[i], 5'(i), (i == 31)});
        end
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int base;
        int n;
        base = done_seen;
        n = 0;
        while (done_seen == base && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 64'(done_seen != base), 64'd1);
    endtask

    task automatic wait_word(input string name, input logic [4:0] idx, input int bound);
        int n;
        n = 0;
        while (!(out_valid === 1'b1 && out_index == idx) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(out_valid === 1'b1 && out_index == idx), 64'd1);
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
        rf[0] = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        rst = 1'b0; start = 1'b1; abort = 1'b0; start1 = 1'b1;
        preload_ramp();

        // Reset state with start held high during reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({out_valid, out_data, out_index, out_last, busy, done, rf_addr}), 64'd0);
        chk("reset_outputs_single", 64'({out_valid1, out_data1, out_index1, out_last1, busy1, done1, rf_addr1}), 64'd0);
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_reset_discarded", 64'(busy), 64'd0);
        chk("no_done_after_reset", 64'(done_seen), 64'd0);

        // Full ramp dump with continuous ready
        ready_mode = 0;
        spacing_en = 1'b1;
        issue_dump();
        wait_done("full_dump_done", 200);
        chk("full_dump_cycles", 64'(done_cyc - start_cyc), 64'd64);
        chk("full_dump_done_count", 64'(done_seen), 64'd1);
        chk("full_dump_drained", 64'(sb_q.size()), 64'd0);
        spacing_en = 1'b0;

        // Backpressure on index 3; register rewritten after capture
        hold_idx = 5'd3;
        ready_mode = 3;
        issue_dump();
        wait_word("bp_reach_3", 5'd3, 50);
        rf[3] = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_stable", 64'({out_valid, out_index, out_data, out_last}), 64'({1'b1, 5'd3, 32'h1003, 1'b0}));
            @(negedge clk);
        end
        ready_mode = 0;
        wait_done("bp_done", 200);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);
        rf[3] = 32'h1003;

        // Abort while presenting index 7
        base = done_seen;
        hold_idx = 5'd7;
        ready_mode = 3;
        issue_dump();
        wait_word("abort_reach_7", 5'd7, 50);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_clears_valid", 64'(out_valid), 64'd0);
        chk("abort_clears_busy", 64'(busy), 64'd0);
        sb_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_seen - base), 64'd0);
        ready_mode = 0;
        issue_dump();
        wait_done("after_abort_done", 200);
        chk("after_abort_drained", 64'(sb_q.size()), 64'd0);

        // Start re-pulsed while busy at index 10
        base = done_seen;
        issue_dump();
        wait_word("busy_reach_10", 5'd10, 100);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start_done", 200);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_start_idle_after", 64'(busy), 64'd0);
        chk("busy_start_one_done", 64'(done_seen - base), 64'd1);
        chk("busy_start_drained", 64'(sb_q.size()), 64'd0);

        // Reset mid-dump around index 20
        base = done_seen;
        issue_dump();
        wait_word("reset_reach_20", 5'd20, 100);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midreset_outputs", 64'({out_valid, out_data, out_index, out_last, busy, done, rf_addr}), 64'd0);
        sb_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_no_done", 64'(done_seen - base), 64'd0);
        issue_dump();
        wait_done("after_reset_done", 200);
        chk("after_reset_drained", 64'(sb_q.size()), 64'd0);

        // Abort coinciding with the final handshake
        base = done_seen;
        hold_idx = 5'd31;
        ready_mode = 3;
        issue_dump();
        wait_word("final_reach_31", 5'd31, 100);
        ready_mode = 0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("final_abort_state", 64'({busy, out_valid, done}), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("final_abort_no_done", 64'(done_seen - base), 64'd0);
        chk("final_abort_drained", 64'(sb_q.size()), 64'd0);

        // Randomized contents with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i < 32; i++) rf[i] = $urandom;
            rf[0] = 32'd0;
            base = done_seen;
            ready_mode = 1;
            issue_dump();
            wait_done("random_done", 1500);
            chk("random_drained", 64'(sb_q.size()), 64'd0);
            chk("random_one_done", 64'(done_seen - base), 64'd1);
        end
        ready_mode = 0;

        // Single-register configuration FIRST_REG = LAST_REG = 5
        rf[5] = 32'hA5A5_0005;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (out_valid1 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("single_word", 64'({out_valid1, out_index1, out_data1, out_last1}), 64'({1'b1, 5'd5, 32'hA5A5_0005, 1'b1}));
        @(negedge clk);
        chk("single_done", 64'({done1, out_valid1}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        chk("single_idle", 64'({done1, busy1}), 64'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
